core_sequencer: RTL and testbench
=================================

# core_sequencer

Multicycle instruction sequencer for the 16-bit core datapath. It fetches 16-bit instructions from a synchronous-read instruction ROM and latches them into an instruction register that drives the datapath. It then generates the datapath phase enables (`en_s` operand load, `en_c` ALU result capture, `en_reg` one-hot register write). It also resolves conditional branches from the datapath's `branch_res` flag and holds the program counter.

## Interface
- `PC_W`, default 8: program counter / ROM address width; PC wraps modulo 2^PC_W.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `run` in 1: global enable. While low, the FSM and PC hold, and all enables and `done` are forced low.
- `start` in 1: in IDLE or HALT, starts the program from PC 0 (needs `run` high).
- `imem_addr` out PC_W: ROM address, always equal to `pc`.
- `imem_rdata` in 16: ROM data, valid the cycle after the address is sampled.
- `branch_res` in 1: datapath condition flag, sampled in the BRANCH state.
- `instruction` out 16: instruction register (IR) driven to the datapath.
- `en_s` out 1: operand-load phase enable.
- `en_c` out 1: ALU-capture phase enable.
- `en_reg` out 8: one-hot register write enable, indexed by IR[15:13].
- `pc` out PC_W: current program counter.
- `done` out 1: 1-cycle pulse when an instruction retires.
- `halted` out 1: level, high in the HALT state.
- `retired` out 16: count of retired instructions; wraps at 2^16.

## Operation
- **Instruction fields:** Rx = [15:13], Ry = [12:10], sel = [4:2], fmt = [1:0].
  - fmt 0: register-register.
  - fmt 1: immediate (the datapath uses [12:5]).
  - fmt 2: branch, with signed offset off8 = [12:5].
  - fmt 3: halt.
- **States:** IDLE, FETCH, DECODE, LOAD, EXEC, WRITE, BRANCH, HALT.
- **IDLE:** if `start`, set pc←0 and go to FETCH.
- **FETCH:** ROM samples `imem_addr`. Go to DECODE.
- **DECODE:** IR←`imem_rdata`. Next state is chosen from `imem_rdata[1:0]`, not from the old IR:
  - fmt 0/1 → LOAD
  - fmt 2 → BRANCH
  - fmt 3 → HALT
- **LOAD:** `en_s`=1. Go to EXEC.
- **EXEC:** `en_c`=1. Go to WRITE.
- **WRITE:**
  - `en_reg` = 1<<IR[15:13] (exactly one bit set).
  - `done`=1, pc←pc+1, retired←retired+1.
  - Go to FETCH.
- **BRANCH:**
  - If `branch_res`, pc ← pc + sign_extend(off8) truncated to PC_W; otherwise pc←pc+1.
  - `done`=1, retired+1. Go to FETCH.
  - A branch writes no register: `en_reg`=0.
- **HALT:** `halted`=1 and all enables are 0. `start` sets pc←0, retired is kept, and the FSM goes to FETCH.
- **Enable decoding:** the enables are Moore decodes of the state register, ANDed with `run`. In any one cycle at most one of `en_s`, `en_c`, or `en_reg`≠0 is active.
- **`run` low:** state, pc, IR and retired are all frozen. When `run` rises again, the same state resumes and its enable is asserted then. No phase is skipped or repeated.
- **`start` outside IDLE/HALT:** ignored.
- **PC arithmetic:** modulo 2^PC_W.
  - Example with PC_W=8: pc=0xFF in WRITE → 0x00.
  - Example with PC_W=8: pc=0x02 with off8=0xFC, taken → 0xFE.

## Timing
- **Reset values:** state=IDLE; pc=0, IR=0, retired=0; `en_s`=`en_c`=0, `en_reg`=0; `done`=0, `halted`=0; `imem_addr`=0.
- **Reset mid-instruction:** the reset edge aborts the instruction. There is no `en_reg` or `done` in the following cycle, and the next cycle is IDLE.
- **Instruction latency (with `run` held high):**
  - fmt 0/1 takes 5 cycles: FETCH, DECODE, LOAD, EXEC, WRITE.
  - fmt 2 takes 3 cycles: FETCH, DECODE, BRANCH.
  - fmt 3 takes 2 cycles to reach HALT.
- **First fetch:** the cycle after `start` is sampled is FETCH.
- **`instruction` output:** valid from LOAD/BRANCH onward and stable through WRITE.
- **`branch_res`:** sampled only on the BRANCH-cycle edge. Its value in any other cycle is ignored.
- **`done`:** asserted in the same cycle as the WRITE or BRANCH state. `pc` and `retired` show their new values the following cycle.

## Test plan
- **Reset:** reset high 2 cycles, then `run`=1 with no `start` → stays IDLE, all outputs 0, `imem_addr`=0.
- **Register instruction:** ROM[0]=16'h4000 (Rx=2, fmt 0), `start` pulse → `en_s`, `en_c`, `en_reg`=8'h04 in consecutive cycles 3-5 after start; `done` in cycle 5; pc=1 and retired=1 afterwards.
- **Branch:** ROM[0]=branch off8=+3 (16'h0062).
  - With `branch_res`=1: pc=3 after 3 cycles.
  - Repeat with `branch_res`=0: pc=1.
  - In both cases `en_reg` stays 0.
- **Backward wrap:** PC_W=8, start at pc=0 with ROM[0]=branch off8=0xFC taken → pc=0xFC. Also, a fmt 0 instruction at 0xFF retires to pc=0x00.
- **Stall:** drop `run` during EXEC for 4 cycles → `en_c` low while stalled, reasserted for exactly 1 cycle after `run` rises; `en_reg` follows next cycle; total 9 cycles.
- **Halt and reset abort:** ROM[1]=16'h0003 → `halted`=1 two cycles after its FETCH; `start` restarts at pc 0 with retired unchanged. Asserting `reset` during EXEC produces no `en_reg` or `done`.

Source files
------------

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multicycle fetch/decode/phase sequencer for the 16-bit core datapath
// Holds PC, IR and the retired-instruction count; phase enables are state decodes gated by run.
module core_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            branch_res,
  output logic [15:0]     instruction,
  output logic            en_s,
  output logic            en_c,
  output logic [7:0]      en_reg,
  output logic [PC_W-1:0] pc,
  output logic            done,
  output logic            halted,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_LOAD   = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [15:0]       r_retired;

  logic signed [7:0] w_off8;
  logic [PC_W-1:0]   w_off;
  logic [PC_W-1:0]   w_pc_inc;

  assign w_off8   = r_ir[12:5];
  assign w_off    = PC_W'(w_off8);
  assign w_pc_inc = r_pc + PC_W'(1);

  // Everything freezes while run is low, so a stalled phase resumes unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
    end else if (run) begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc    <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_ir <= imem_rdata;
          case (imem_rdata[1:0])
            2'd0, 2'd1: r_state <= S_LOAD;
            2'd2:       r_state <= S_BRANCH;
            default:    r_state <= S_HALT;
          endcase
        end
        S_LOAD:   r_state <= S_EXEC;
        S_EXEC:   r_state <= S_WRITE;
        S_WRITE: begin
          r_pc      <= w_pc_inc;
          r_retired <= r_retired + 16'd1;
          r_state   <= S_FETCH;
        end
        S_BRANCH: begin
          r_pc      <= branch_res ? (r_pc + w_off) : w_pc_inc;
          r_retired <= r_retired + 16'd1;
          r_state   <= S_FETCH;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_ir;
  assign retired     = r_retired;

  assign en_s   = run && (r_state == S_LOAD);
  assign en_c   = run && (r_state == S_EXEC);
  assign en_reg = (run && (r_state == S_WRITE)) ? (8'b1 << r_ir[15:13]) : 8'b0;
  assign done   = run && ((r_state == S_WRITE) || (r_state == S_BRANCH));
  assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed and randomized self-checking bench for core_sequencer
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_core_sequencer;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            reset, run, start, branch_res;
  logic [PC_W-1:0] imem_addr, pc;
  logic [15:0]     imem_rdata, instruction, retired;
  logic            en_s, en_c, done, halted;
  logic [7:0]      en_reg;

  logic [15:0] rom [256];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) imem_rdata <= rom[imem_addr];

  core_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .run(run), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .branch_res(branch_res),
    .instruction(instruction), .en_s(en_s), .en_c(en_c), .en_reg(en_reg),
    .pc(pc), .done(done), .halted(halted), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ph_vec();
    return {21'd0, en_s, en_c, en_reg, done};
  endfunction

  function automatic logic [31:0] ph(input logic s, input logic c, input logic [7:0] r, input logic d);
    return {21'd0, s, c, r, d};
  endfunction

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; start = 1'b0; branch_res = 1'b0;
    adv(); adv();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    run = 1'b1; start = 1'b1;
    adv();
    start = 1'b0;
  endtask

  task automatic advn(input int n);
    for (int i = 0; i < n; i++) adv();
  endtask

  // Reference model: per instruction, derive the phase list and architectural
  // result from the instruction fields; phases only advance on run-high cycles.
  task automatic rand_run(input int n_instr);
    logic [PC_W-1:0] m_pc;
    logic [15:0]     m_ret;
    logic [15:0]     inst;
    logic [7:0]      e_reg;
    logic            br, taken;
    int              phs[$];
    int              off;
    do_reset();
    for (int a = 0; a < 256; a++) begin
      inst = 16'($urandom);
      if (inst[1:0] == 2'd3 && $urandom_range(0, 9) != 0) inst[1:0] = 2'($urandom_range(0, 2));
      rom[a] = inst;
    end
    m_pc = '0; m_ret = '0;
    pulse_start();
    for (int k = 0; k < n_instr; k++) begin
      inst = rom[m_pc];
      phs.delete();
      phs.push_back(0); phs.push_back(1);
      if (inst[1:0] < 2'd2) begin phs.push_back(2); phs.push_back(3); phs.push_back(4); end
      else if (inst[1:0] == 2'd2) phs.push_back(5);
      br = 1'b0;
      foreach (phs[j]) begin
        do begin
          run        = ($urandom_range(0, 3) != 0);
          branch_res = 1'($urandom_range(0, 1));
          start      = ($urandom_range(0, 7) == 0);
          #1;
          e_reg = (run && phs[j] == 4) ? (8'b1 << inst[15:13]) : 8'h00;
          check("rnd_ph", ph_vec(), ph(run && phs[j] == 2, run && phs[j] == 3, e_reg,
                                       run && (phs[j] == 4 || phs[j] == 5)));
          check("rnd_pc", 32'(pc), 32'(m_pc));
          check("rnd_ret", 32'(retired), 32'(m_ret));
          check("rnd_halt", 32'(halted), 32'd0);
          if (phs[j] >= 2) check("rnd_ir", 32'(instruction), 32'(inst));
          @(posedge clk);
          taken = run;
          if (phs[j] == 5 && run) br = branch_res;
          @(negedge clk);
        end while (!taken);
      end
      start = 1'b0;
      if (inst[1:0] == 2'd3) begin
        for (int h = 0; h < 3; h++) begin
          run = 1'($urandom_range(0, 1));
          #1;
          check("rnd_halted", 32'(halted), 32'd1);
          check("rnd_halt_ph", ph_vec(), 32'd0);
          check("rnd_halt_ret", 32'(retired), 32'(m_ret));
          adv();
        end
        pulse_start();
        m_pc = '0;
      end else begin
        off = (inst[1:0] == 2'd2 && br) ? int'($signed(inst[12:5])) : 1;
        m_pc  = PC_W'((int'(m_pc) + off) & ((1 << PC_W) - 1));
        m_ret = m_ret + 16'd1;
      end
    end
    run = 1'b1; start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    reset = 1'b1; run = 1'b0; start = 1'b0; branch_res = 1'b0;
    adv();

    // reset state, idle without start
    do_reset();
    run = 1'b1;
    #1;
    check("rst_ph", ph_vec(), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_ir", 32'(instruction), 32'd0);
    check("rst_ret", 32'(retired), 32'd0);
    check("rst_halt", 32'(halted), 32'd0);
    advn(3);
    #1;
    check("idle_ph", ph_vec(), 32'd0);
    check("idle_pc", 32'(pc), 32'd0);

    // register instruction
    rom[0] = 16'h4000;
    do_reset();
    pulse_start();
    #1 check("reg_c1", ph_vec(), 32'd0); adv();
    #1 check("reg_c2", ph_vec(), 32'd0); adv();
    #1 check("reg_c3", ph_vec(), ph(1'b1, 1'b0, 8'h00, 1'b0)); adv();
    #1 check("reg_c4", ph_vec(), ph(1'b0, 1'b1, 8'h00, 1'b0)); adv();
    #1 check("reg_c5", ph_vec(), ph(1'b0, 1'b0, 8'h04, 1'b1));
    check("reg_ir", 32'(instruction), 32'h4000); adv();
    #1 check("reg_pc", 32'(pc), 32'd1);
    check("reg_ret", 32'(retired), 32'd1);

    // branch taken / not taken
    for (int t = 0; t < 2; t++) begin
      rom[0] = 16'h0062;
      do_reset();
      branch_res = (t == 0);
      pulse_start();
      adv();
      branch_res = ~branch_res;
      #1 check("br_c2", ph_vec(), 32'd0);
      adv();
      branch_res = (t == 0);
      #1 check("br_c3", ph_vec(), ph(1'b0, 1'b0, 8'h00, 1'b1)); adv();
      #1 check("br_pc", 32'(pc), (t == 0) ? 32'd3 : 32'd1);
      check("br_ret", 32'(retired), 32'd1);
    end

    // backward wrap and pc wrap past 0xFF
    rom[0] = 16'h1F82;
    do_reset();
    branch_res = 1'b1;
    pulse_start();
    advn(3);
    #1 check("bwrap_pc", 32'(pc), 32'hFC);
    rom[0] = 16'h1FE2;
    rom[8'hFF] = 16'hE000;
    do_reset();
    branch_res = 1'b1;
    pulse_start();
    advn(3);
    #1 check("to_ff_pc", 32'(pc), 32'hFF);
    advn(4);
    #1 check("ff_write", ph_vec(), ph(1'b0, 1'b0, 8'h80, 1'b1)); adv();
    #1 check("ff_wrap_pc", 32'(pc), 32'h00);
    check("ff_wrap_ret", 32'(retired), 32'd2);

    // stall during EXEC
    rom[0] = 16'h4000;
    do_reset();
    pulse_start();
    advn(3);
    run = 1'b0;
    for (int s = 0; s < 4; s++) begin
      #1 check("stall_ph", ph_vec(), 32'd0);
      check("stall_pc", 32'(pc), 32'd0);
      adv();
    end
    run = 1'b1;
    #1 check("stall_c8", ph_vec(), ph(1'b0, 1'b1, 8'h00, 1'b0)); adv();
    #1 check("stall_c9", ph_vec(), ph(1'b0, 1'b0, 8'h04, 1'b1)); adv();
    #1 check("stall_pc_end", 32'(pc), 32'd1);

    // halt and restart
    rom[0] = 16'h4000;
    rom[1] = 16'h0003;
    do_reset();
    pulse_start();
    advn(5);
    #1 check("halt_fetch_pc", 32'(pc), 32'd1); adv();
    #1 check("halt_c7", 32'(halted), 32'd0); adv();
    #1 check("halt_c8", 32'(halted), 32'd1);
    check("halt_ret", 32'(retired), 32'd1);
    check("halt_ph", ph_vec(), 32'd0);
    adv();
    pulse_start();
    #1 check("restart_pc", 32'(pc), 32'd0);
    check("restart_halt", 32'(halted), 32'd0);
    check("restart_ret", 32'(retired), 32'd1);

    // reset abort during EXEC
    rom[0] = 16'h4000;
    do_reset();
    pulse_start();
    advn(3);
    reset = 1'b1;
    #1 check("abort_exec", ph_vec(), ph(1'b0, 1'b1, 8'h00, 1'b0)); adv();
    reset = 1'b0;
    #1 check("abort_ph", ph_vec(), 32'd0);
    check("abort_ret", 32'(retired), 32'd0); adv();
    #1 check("abort_idle", ph_vec(), 32'd0);

    rand_run(400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
